// File: rtl/anim_pkg.sv
// Shared encodings for the animation frame sequencer: playback modes, FSM states
// and default widths.
package anim_pkg;

    localparam int CNT_W_DEFAULT   = 32;
    localparam int FRAME_W_DEFAULT = 8;

    localparam logic [1:0] MODE_LOOP     = 2'd0;
    localparam logic [1:0] MODE_PINGPONG = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_BWD  = 2'd2
    } state_t;

endpackage

// File: rtl/tick_step_detect.sv
// Turns every change of the upstream prescaled tick count into a one-cycle step,
// suppressing the first cycle after reset so a non-reset upstream count never looks like a change.
module tick_step_detect
    import anim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_tick_cnt,
    output logic             o_step
);

    logic [CNT_W-1:0] r_prevCnt;
    logic             r_primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prevCnt <= '0;
            r_primed  <= 1'b0;
        end else begin
            r_prevCnt <= i_tick_cnt;
            r_primed  <= 1'b1;
        end
    end

    // Any inequality is one step, so a wrap back to zero also counts.
    assign o_step = r_primed && (i_tick_cnt != r_prevCnt);

endmodule

// File: rtl/anim_frame_sequencer.sv
// Walks a frame index across a latched [first, last] range in loop, ping-pong or
// one-shot mode, advancing once per upstream tick-count change.
module anim_frame_sequencer
    import anim_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int FRAME_W = FRAME_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   i_tick_cnt,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic [FRAME_W-1:0] i_first_frame,
    input  logic [FRAME_W-1:0] i_last_frame,
    output logic [FRAME_W-1:0] o_frame_idx,
    output logic               o_busy,
    output logic               o_cycle_done,
    output logic               o_done
);

    state_t             r_state;
    state_t             w_nextState;
    logic [1:0]         r_mode;
    logic [1:0]         w_nextMode;
    logic [FRAME_W-1:0] r_first;
    logic [FRAME_W-1:0] w_nextFirst;
    logic [FRAME_W-1:0] r_last;
    logic [FRAME_W-1:0] w_nextLast;
    logic [FRAME_W-1:0] r_frameIdx;
    logic [FRAME_W-1:0] w_nextFrame;
    logic [FRAME_W-1:0] w_startLast;
    logic               r_busy;
    logic               r_cycleDone;
    logic               w_cycleDone;
    logic               r_done;
    logic               w_done;
    logic               w_step;

    tick_step_detect #(
        .CNT_W (CNT_W)
    ) u_stepDetect (
        .clk        (clk),
        .rst        (rst),
        .i_tick_cnt (i_tick_cnt),
        .o_step     (w_step)
    );

    // An inverted range collapses to the single frame at first.
    assign w_startLast = (i_last_frame < i_first_frame) ? i_first_frame : i_last_frame;

    always_comb begin
        w_nextState = r_state;
        w_nextMode  = r_mode;
        w_nextFirst = r_first;
        w_nextLast  = r_last;
        w_nextFrame = r_frameIdx;
        w_cycleDone = 1'b0;
        w_done      = 1'b0;

        if (i_stop) begin
            w_nextState = ST_IDLE;
        end else if (i_start) begin
            w_nextMode  = i_mode;
            w_nextFirst = i_first_frame;
            w_nextLast  = w_startLast;
            w_nextFrame = i_first_frame;
            w_nextState = ST_FWD;
        end else if (w_step) begin
            case (r_state)
                ST_FWD: begin
                    if (r_frameIdx != r_last) begin
                        w_nextFrame = r_frameIdx + 1'b1;
                    end else begin
                        case (r_mode)
                            MODE_PINGPONG: begin
                                if (r_first == r_last) begin
                                    w_cycleDone = 1'b1;
                                end else begin
                                    w_nextFrame = r_frameIdx - 1'b1;
                                    w_nextState = ST_BWD;
                                end
                            end
                            MODE_ONESHOT: begin
                                w_done      = 1'b1;
                                w_nextState = ST_IDLE;
                            end
                            default: begin
                                w_nextFrame = r_first;
                                w_cycleDone = 1'b1;
                            end
                        endcase
                    end
                end
                // Turning at first steps straight to first+1 so the endpoint shows once.
                ST_BWD: begin
                    if (r_frameIdx != r_first) begin
                        w_nextFrame = r_frameIdx - 1'b1;
                    end else begin
                        w_nextFrame = r_frameIdx + 1'b1;
                        w_nextState = ST_FWD;
                        w_cycleDone = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_LOOP;
            r_first     <= '0;
            r_last      <= '0;
            r_frameIdx  <= '0;
            r_busy      <= 1'b0;
            r_cycleDone <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_mode      <= w_nextMode;
            r_first     <= w_nextFirst;
            r_last      <= w_nextLast;
            r_frameIdx  <= w_nextFrame;
            r_busy      <= (w_nextState != ST_IDLE);
            r_cycleDone <= w_cycleDone;
            r_done      <= w_done;
        end
    end

    assign o_frame_idx  = r_frameIdx;
    assign o_busy       = r_busy;
    assign o_cycle_done = r_cycleDone;
    assign o_done       = r_done;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Testbench for anim_frame_sequencer: directed scenarios plus random control traffic,
// checked against a pattern-position model of the animation.
module tb_anim_frame_sequencer;

    localparam int TICK_MAX = 100000;

    logic        clk;
    logic        rst;
    logic [31:0] tickCnt;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [7:0]  firstFrame;
    logic [7:0]  lastFrame;
    logic [7:0]  frameIdx;
    logic        busy;
    logic        cycleDone;
    logic        done;

    int vectorCount;
    int missCount;
    int cycleNum;

    // Model: position k along the ideal frame pattern of the latched range.
    int mPrevCnt;
    bit mPrimed;
    bit mActive;
    int mMode;
    int mFirst;
    int mLast;
    int mK;
    int mFrame;
    bit mCycleDone;
    bit mDone;

    anim_frame_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .i_tick_cnt    (tickCnt),
        .i_start       (start),
        .i_stop        (stop),
        .i_mode        (mode),
        .i_first_frame (firstFrame),
        .i_last_frame  (lastFrame),
        .o_frame_idx   (frameIdx),
        .o_busy        (busy),
        .o_cycle_done  (cycleDone),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int frameAt(int k);
        int n;
        int p;
        int r;
        n = mLast - mFirst + 1;
        if (mMode == 2) return mFirst + ((k < n - 1) ? k : n - 1);
        if (mMode == 1 && n > 1) begin
            p = 2 * (n - 1);
            r = k % p;
            return (r < n) ? mFirst + r : mFirst + p - r;
        end
        return mFirst + (k % n);
    endfunction

    task automatic modelClock();
        bit stepNow;
        int n;
        mCycleDone = 1'b0;
        mDone      = 1'b0;
        if (rst) begin
            mPrevCnt = 0;
            mPrimed  = 1'b0;
            mActive  = 1'b0;
            mMode    = 0;
            mFirst   = 0;
            mLast    = 0;
            mK       = 0;
            mFrame   = 0;
            return;
        end
        stepNow  = mPrimed && (int'(tickCnt) != mPrevCnt);
        mPrevCnt = int'(tickCnt);
        mPrimed  = 1'b1;
        if (stop) begin
            mActive = 1'b0;
        end else if (start) begin
            mMode   = int'(mode);
            mFirst  = int'(firstFrame);
            mLast   = (lastFrame < firstFrame) ? int'(firstFrame) : int'(lastFrame);
            mK      = 0;
            mActive = 1'b1;
            mFrame  = mFirst;
        end else if (stepNow && mActive) begin
            n = mLast - mFirst + 1;
            if (mMode == 2) begin
                if (mK == n - 1) begin
                    mDone   = 1'b1;
                    mActive = 1'b0;
                end else begin
                    mK++;
                end
            end else if (mMode == 1 && n > 1) begin
                if (mK > 0 && (mK % (2 * (n - 1))) == 0) mCycleDone = 1'b1;
                mK++;
            end else begin
                mK++;
                if ((mK % n) == 0) mCycleDone = 1'b1;
            end
            mFrame = frameAt(mK);
        end
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectorCount++;
        if (got != exp) begin
            missCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNum, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic iRst, input logic iStart, input logic iStop,
                                 input logic [1:0] iMode, input logic [7:0] iFirst,
                                 input logic [7:0] iLast, input logic iAdvance);
        @(negedge clk);
        rst        = iRst;
        start      = iStart;
        stop       = iStop;
        mode       = iMode;
        firstFrame = iFirst;
        lastFrame  = iLast;
        if (iAdvance) tickCnt = (tickCnt == TICK_MAX - 1) ? 32'd0 : tickCnt + 32'd1;
        @(posedge clk);
        modelClock();
        cycleNum++;
        #1;
        checkOutput("frameIdx", int'(frameIdx), mFrame);
        checkOutput("busy", int'(busy), int'(mActive));
        checkOutput("cycleDone", int'(cycleDone), int'(mCycleDone));
        checkOutput("done", int'(done), int'(mDone));
    endtask

    task automatic stepCycles(input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
    endtask

    initial begin
        logic [7:0] rFirst;
        logic [7:0] rLast;
        int sel;
        vectorCount = 0;
        missCount   = 0;
        cycleNum    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        mode        = 2'd0;
        firstFrame  = 8'd0;
        lastFrame   = 8'd0;
        tickCnt     = 32'd5;

        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        tickCnt = 32'd7;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd2, 8'd4, 1'b0);
        stepCycles(7);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 8'd3, 1'b0);
        stepCycles(8);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 8'd0, 8'd2, 1'b0);
        stepCycles(5);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd9, 8'd12, 1'b1);
        stepCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 8'd40, 8'd50, 1'b1);
        stepCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd5, 8'd1, 1'b0);
        stepCycles(3);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 8'd253, 8'd255, 1'b0);
        tickCnt = TICK_MAX - 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        stepCycles(4);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 8'd250, 8'd255, 1'b0);
        stepCycles(7);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                rFirst = 8'($urandom_range(0, 255));
                rLast  = 8'(int'(rFirst) + int'($urandom_range(0, 5)));
            end else if (sel < 8) begin
                rFirst = 8'($urandom_range(248, 255));
                rLast  = 8'd255;
            end else begin
                rFirst = 8'($urandom_range(0, 255));
                rLast  = 8'($urandom_range(0, 255));
            end
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 39) == 0),
                          2'($urandom_range(0, 3)),
                          rFirst, rLast,
                          ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
